// File: rtl/snake_pkg.sv
// Shared snake-game definitions: grid defaults, coordinate width and the
// food placer state encoding.
package snake_pkg;

  localparam int COORD_W = 8;
  localparam int GRID_W  = 40;
  localparam int GRID_H  = 30;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [2:0] {
    PL_IDLE,
    PL_SAMPLE,
    PL_CHECK,
    PL_SCAN,
    PL_SCAN_CHECK
  } placer_state_t;

endpackage

// File: rtl/grid_cursor.sv
// Row-major x/y cursor over the grid with load, single-cell advance and
// wrap-around; load and step together yield the cell after the loaded one.
module grid_cursor import snake_pkg::*; #(
  parameter int GRID_W = snake_pkg::GRID_W,
  parameter int GRID_H = snake_pkg::GRID_H
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   load,
  input  logic   step,
  input  coord_t load_x,
  input  coord_t load_y,
  output coord_t x,
  output coord_t y
);

  localparam coord_t X_MAX = coord_t'(GRID_W - 1);
  localparam coord_t Y_MAX = coord_t'(GRID_H - 1);

  coord_t base_x, base_y;
  coord_t next_x, next_y;

  // Out-of-range loads wrap like the last column/row so the cursor always
  // lands back inside the grid after one step.
  always_comb begin
    base_x = load ? load_x : x;
    base_y = load ? load_y : y;
    next_x = base_x;
    next_y = base_y;
    if (step) begin
      if (base_x >= X_MAX) begin
        next_x = '0;
        next_y = (base_y >= Y_MAX) ? '0 : base_y + coord_t'(1);
      end else begin
        next_x = base_x + coord_t'(1);
        if (base_y > Y_MAX) next_y = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (load || step) begin
      x <= next_x;
      y <= next_y;
    end
  end

endmodule

// File: rtl/food_placer.sv
// Picks a free food cell: bounded random sampling against the occupancy RAM,
// then a deterministic wrap-around scan so placement always terminates.
module food_placer import snake_pkg::*; #(
  parameter int GRID_W    = snake_pkg::GRID_W,
  parameter int GRID_H    = snake_pkg::GRID_H,
  parameter int MAX_TRIES = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       place_req,
  input  logic [7:0] rand_x,
  input  logic [7:0] rand_y,
  output logic [7:0] rand_max_x,
  output logic [7:0] rand_max_y,
  output logic       occ_rd_en,
  output logic [7:0] occ_x,
  output logic [7:0] occ_y,
  input  logic       occ_rd_data,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic       food_valid,
  output logic [7:0] food_x,
  output logic [7:0] food_y
);

  localparam logic [8:0]  W_LIM   = 9'(GRID_W);
  localparam logic [8:0]  H_LIM   = 9'(GRID_H);
  localparam logic [7:0]  TRY_LIM = 8'(MAX_TRIES);
  localparam logic [16:0] CELLS   = 17'(GRID_W * GRID_H);

  placer_state_t state, next_state;

  logic [7:0]  tries;
  logic [16:0] scan_cnt;
  coord_t      cand_x, cand_y;
  logic        cand_ok;
  logic        rand_ok;
  logic        cur_load, cur_step;
  coord_t      cur_x, cur_y;

  assign rand_max_x = coord_t'(GRID_W - 1);
  assign rand_max_y = coord_t'(GRID_H - 1);
  assign busy       = (state != PL_IDLE);
  assign rand_ok    = ({1'b0, rand_x} < W_LIM) && ({1'b0, rand_y} < H_LIM);

  grid_cursor #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H)
  ) u_cursor (
    .clock  (clock),
    .reset  (reset),
    .load   (cur_load),
    .step   (cur_step),
    .load_x (cand_x),
    .load_y (cand_y),
    .x      (cur_x),
    .y      (cur_y)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= PL_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    occ_rd_en  = 1'b0;
    occ_x      = '0;
    occ_y      = '0;
    cur_load   = 1'b0;
    cur_step   = 1'b0;
    case (state)
      PL_IDLE: begin
        if (place_req) next_state = PL_SAMPLE;
      end
      PL_SAMPLE: begin
        if (rand_ok) begin
          occ_rd_en = 1'b1;
          occ_x     = rand_x;
          occ_y     = rand_y;
        end
        next_state = PL_CHECK;
      end
      PL_CHECK: begin
        if (cand_ok && !occ_rd_data) begin
          next_state = PL_IDLE;
        end else if (tries == TRY_LIM) begin
          next_state = PL_SCAN;
          cur_load   = 1'b1;
          cur_step   = 1'b1;
        end else begin
          next_state = PL_SAMPLE;
        end
      end
      PL_SCAN: begin
        occ_rd_en  = 1'b1;
        occ_x      = cur_x;
        occ_y      = cur_y;
        next_state = PL_SCAN_CHECK;
      end
      PL_SCAN_CHECK: begin
        if (!occ_rd_data || scan_cnt == CELLS) begin
          next_state = PL_IDLE;
        end else begin
          cur_step   = 1'b1;
          next_state = PL_SCAN;
        end
      end
      default: next_state = PL_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tries      <= '0;
      scan_cnt   <= '0;
      cand_x     <= '0;
      cand_y     <= '0;
      cand_ok    <= 1'b0;
      done       <= 1'b0;
      fail       <= 1'b0;
      food_valid <= 1'b0;
      food_x     <= '0;
      food_y     <= '0;
    end else begin
      done <= 1'b0;
      fail <= 1'b0;
      case (state)
        PL_IDLE: begin
          tries <= '0;
          if (place_req) food_valid <= 1'b0;
        end
        PL_SAMPLE: begin
          cand_x  <= rand_x;
          cand_y  <= rand_y;
          cand_ok <= rand_ok;
          tries   <= tries + 8'd1;
        end
        PL_CHECK: begin
          if (cand_ok && !occ_rd_data) begin
            food_x     <= cand_x;
            food_y     <= cand_y;
            food_valid <= 1'b1;
            done       <= 1'b1;
          end else if (tries == TRY_LIM) begin
            scan_cnt <= '0;
          end
        end
        PL_SCAN: begin
          scan_cnt <= scan_cnt + 17'd1;
        end
        PL_SCAN_CHECK: begin
          if (!occ_rd_data) begin
            food_x     <= cur_x;
            food_y     <= cur_y;
            food_valid <= 1'b1;
            done       <= 1'b1;
          end else if (scan_cnt == CELLS) begin
            done <= 1'b1;
            fail <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
